// File: rtl/quant_block_pipe.sv
// quant_block_pipe: handshaked VP8 4x4 quantizer, LANES coefficients per cycle in zigzag order.
// Optional feature macro QUANT_CLAMP_CNT_EN adds clamp_cnt (count of clamped non-zero levels).
module quant_block_pipe #(
  parameter int IW        = 16,
  parameter int LANES     = 4,
  parameter int QFIX      = 17,
  parameter int MAX_LEVEL = 2047
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            first_coeff,
  input  logic [16*IW-1:0] in,
  input  logic [255:0]    q,
  input  logic [255:0]    iq,
  input  logic [511:0]    bias,
  input  logic [511:0]    zthresh,
  input  logic [255:0]    sharpen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [255:0]    out,
  output logic [255:0]    rout,
  output logic            nz,
  output logic [4:0]      last
`ifdef QUANT_CLAMP_CNT_EN
  ,
  output logic [4:0]      clamp_cnt
`endif
);
  localparam int G      = 16 / LANES;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
  state_t state, state_nxt;

  logic [15:0][IW-1:0] cap_in;
  logic [15:0][15:0]   cap_q, cap_iq, cap_sh;
  logic [15:0][31:0]   cap_bias, cap_zt;
  logic                cap_fc;

  logic [3:0]          cnt, grp0, grp1;
  logic [STAGES:0]     vld_pipe;
  logic                issue, accept;
  logic [15:0][15:0]   lvl_buf, rout_buf;
  logic                nz_r;
  logic [4:0]          last_r;
  logic [LANES-1:0][15:0] lane_lvl, lane_rout;
`ifdef QUANT_CLAMP_CNT_EN
  logic [LANES-1:0]    lane_ovf;
  logic [4:0]          cc_r;
`endif

  function automatic logic [3:0] zz(input logic [3:0] k);
    case (k)
      4'd0: zz = 4'd0;   4'd1: zz = 4'd1;   4'd2: zz = 4'd4;   4'd3: zz = 4'd8;
      4'd4: zz = 4'd5;   4'd5: zz = 4'd2;   4'd6: zz = 4'd3;   4'd7: zz = 4'd6;
      4'd8: zz = 4'd9;   4'd9: zz = 4'd12;  4'd10: zz = 4'd13; 4'd11: zz = 4'd10;
      4'd12: zz = 4'd7;  4'd13: zz = 4'd11; 4'd14: zz = 4'd14; default: zz = 4'd15;
    endcase
  endfunction

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // DRAIN waits on the valid pipe itself, so the exit lines up with the last buffer write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == 4'(G-1)) state_nxt = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == HOLD);
    issue     = (state == RUN);
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk)
    if (accept) begin
      cap_in   <= in;
      cap_q    <= q;
      cap_iq   <= iq;
      cap_sh   <= sharpen;
      cap_bias <= bias;
      cap_zt   <= zthresh;
      cap_fc   <= first_coeff;
    end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0]  r;
    logic [31:0] cext, mag, a;
    logic [47:0] sum, raw;
    logic        ovf_c, pass_c;
    logic [15:0] lv_c, s1_lv, s1_q;
    logic        s1_pass, s1_neg;

    assign r = zz(4'(int'(grp0) * LANES + l));

    always_comb begin
      cext   = {{(32-IW){cap_in[r][IW-1]}}, cap_in[r]};
      mag    = cap_in[r][IW-1] ? (~cext + 32'd1) : cext;
      a      = mag + {16'd0, cap_sh[r]};
      sum    = {16'd0, a} * {32'd0, cap_iq[r]} + {16'd0, cap_bias[r]};
      raw    = sum >> QFIX;
      ovf_c  = raw > 48'(MAX_LEVEL);
      lv_c   = ovf_c ? 16'(MAX_LEVEL) : raw[15:0];
      pass_c = (a > cap_zt[r]) && !(cap_fc && r == 4'd0);
    end

    always_ff @(posedge clk)
      if (vld_pipe[0]) begin
        s1_lv   <= lv_c;
        s1_q    <= cap_q[r];
        s1_pass <= pass_c;
        s1_neg  <= cap_in[r][IW-1];
      end

    assign lane_lvl[l]  = s1_pass ? (s1_neg ? -s1_lv : s1_lv) : 16'd0;
    assign lane_rout[l] = lane_lvl[l] * s1_q;

`ifdef QUANT_CLAMP_CNT_EN
    logic s1_ovf;
    always_ff @(posedge clk)
      if (vld_pipe[0]) s1_ovf <= ovf_c;
    // a clamped lv is MAX_LEVEL, so it is non-zero exactly when it passes
    assign lane_ovf[l] = s1_ovf && s1_pass;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      cnt      <= '0;
      grp0     <= '0;
      grp1     <= '0;
      lvl_buf  <= '0;
      rout_buf <= '0;
      nz_r     <= 1'b0;
      last_r   <= '0;
`ifdef QUANT_CLAMP_CNT_EN
      cc_r     <= '0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      grp0     <= cnt;
      grp1     <= grp0;
      if (issue) cnt <= cnt + 4'd1;
      if (accept) begin
        cnt      <= '0;
        lvl_buf  <= '0;
        rout_buf <= '0;
        nz_r     <= 1'b0;
        last_r   <= '0;
`ifdef QUANT_CLAMP_CNT_EN
        cc_r     <= '0;
`endif
      end
      // slots retire in ascending order, so the highest non-zero lane sets last
      if (vld_pipe[STAGES]) begin
        for (int l = 0; l < LANES; l++) begin
          lvl_buf[4'(int'(grp1) * LANES + l)]      <= lane_lvl[l];
          rout_buf[zz(4'(int'(grp1) * LANES + l))] <= lane_rout[l];
          if (lane_lvl[l] != 16'd0) begin
            nz_r   <= 1'b1;
            last_r <= 5'(int'(grp1) * LANES + l + 1);
          end
        end
`ifdef QUANT_CLAMP_CNT_EN
        cc_r <= cc_r + 5'($countones(lane_ovf));
`endif
      end
    end
  end

  always_comb begin
    out  = '0;
    rout = '0;
    nz   = 1'b0;
    last = '0;
`ifdef QUANT_CLAMP_CNT_EN
    clamp_cnt = '0;
`endif
    if (out_valid) begin
      out  = lvl_buf;
      rout = rout_buf;
      nz   = nz_r;
      last = last_r;
`ifdef QUANT_CLAMP_CNT_EN
      clamp_cnt = cc_r;
`endif
    end
  end
endmodule
